// File: rtl/palette_pixel_reader.sv
// Palette read side: priority mux, palette lookup and 2C02 RGB conversion.
// Three-stage pixel pipeline with sync/blank kept aligned; owns sprite-0 hit.
module palette_pixel_reader #(
   parameter logic [23:0] BLANK_RGB = 24'h000000,
   parameter int          LATENCY   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_valid,
   input  logic [3:0] bg_pix,
   input  logic [3:0] spr_pix,
   input  logic       spr_behind,
   input  logic       spr_zero,
   input  logic       show_bg,
   input  logic       show_spr,
   input  logic       grayscale,
   input  logic       blank_in,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic       clr_sprite0,
   output logic [4:0] pal_addr,
   input  logic [7:0] pal_data,
   output logic [7:0] red,
   output logic [7:0] green,
   output logic [7:0] blue,
   output logic       rgb_valid,
   output logic       blank_out,
   output logic       hsync_out,
   output logic       vsync_out,
   output logic       sprite0_hit
);

   logic               bg_op;
   logic               sp_op;
   logic               spr_wins;
   logic               hit_set;
   logic [4:0]         addr_nxt;
   logic               gray_d1;
   logic [5:0]         cidx;
   logic [1:0]         vld_pipe;
   logic [LATENCY-1:0] bl_pipe;
   logic [LATENCY-1:0] hs_pipe;
   logic [LATENCY-1:0] vs_pipe;
   logic               unused_pal_hi;

   assign unused_pal_hi = ^pal_data[7:6];

   assign bg_op    = show_bg & (bg_pix[1:0] != 2'b00);
   assign sp_op    = show_spr & (spr_pix[1:0] != 2'b00);
   assign spr_wins = sp_op & (!bg_op | !spr_behind);
   assign hit_set  = pix_valid & spr_zero & bg_op
                   & sp_op & !blank_in;

   // Fully transparent pixels always hit the universal backdrop,
   // so the $10/$14/$18/$1C mirrors never need handling here.
   always_comb begin
      addr_nxt = {1'b0, bg_pix};
      unique case (1'b1)
         (!bg_op & !sp_op): addr_nxt = 5'h00;
         spr_wins:          addr_nxt = {1'b1, spr_pix};
         default:           addr_nxt = {1'b0, bg_pix};
      endcase
   end

   function automatic logic [23:0] nes_rgb(
      input logic [5:0] c
   );
      case (c)
         6'h00: nes_rgb = 24'h7C7C7C;
         6'h01: nes_rgb = 24'h0000FC;
         6'h02: nes_rgb = 24'h0000BC;
         6'h03: nes_rgb = 24'h4428BC;
         6'h04: nes_rgb = 24'h940084;
         6'h05: nes_rgb = 24'hA80020;
         6'h06: nes_rgb = 24'hA81000;
         6'h07: nes_rgb = 24'h881400;
         6'h08: nes_rgb = 24'h503000;
         6'h09: nes_rgb = 24'h007800;
         6'h0A: nes_rgb = 24'h006800;
         6'h0B: nes_rgb = 24'h005800;
         6'h0C: nes_rgb = 24'h004058;
         6'h10: nes_rgb = 24'hBCBCBC;
         6'h11: nes_rgb = 24'h0078F8;
         6'h12: nes_rgb = 24'h0058F8;
         6'h13: nes_rgb = 24'h6844FC;
         6'h14: nes_rgb = 24'hD800CC;
         6'h15: nes_rgb = 24'hE40058;
         6'h16: nes_rgb = 24'hF83800;
         6'h17: nes_rgb = 24'hE45C10;
         6'h18: nes_rgb = 24'hAC7C00;
         6'h19: nes_rgb = 24'h00B800;
         6'h1A: nes_rgb = 24'h00A800;
         6'h1B: nes_rgb = 24'h00A844;
         6'h1C: nes_rgb = 24'h008888;
         6'h20: nes_rgb = 24'hFCFCFC;
         6'h21: nes_rgb = 24'h3CBCFC;
         6'h22: nes_rgb = 24'h5C94FC;
         6'h23: nes_rgb = 24'h9878F8;
         6'h24: nes_rgb = 24'hF878F8;
         6'h25: nes_rgb = 24'hF85898;
         6'h26: nes_rgb = 24'hF87858;
         6'h27: nes_rgb = 24'hFCA044;
         6'h28: nes_rgb = 24'hF8B800;
         6'h29: nes_rgb = 24'hB8F818;
         6'h2A: nes_rgb = 24'h58D854;
         6'h2B: nes_rgb = 24'h58F898;
         6'h2C: nes_rgb = 24'h00E8D8;
         6'h2D: nes_rgb = 24'h787878;
         6'h30: nes_rgb = 24'hFCFCFC;
         6'h31: nes_rgb = 24'hA4E4FC;
         6'h32: nes_rgb = 24'hB8B8F8;
         6'h33: nes_rgb = 24'hD8B8F8;
         6'h34: nes_rgb = 24'hF8B8F8;
         6'h35: nes_rgb = 24'hF8A4C0;
         6'h36: nes_rgb = 24'hF0D0B0;
         6'h37: nes_rgb = 24'hFCE0A8;
         6'h38: nes_rgb = 24'hF8D878;
         6'h39: nes_rgb = 24'hD8F878;
         6'h3A: nes_rgb = 24'hB8F8B8;
         6'h3B: nes_rgb = 24'hB8F8D8;
         6'h3C: nes_rgb = 24'h00FCFC;
         6'h3D: nes_rgb = 24'hF8D8F8;
         default: nes_rgb = 24'h000000;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         pal_addr <= 5'h00;
         gray_d1  <= 1'b0;
         cidx     <= 6'h00;
         vld_pipe <= '0;
         bl_pipe  <= '1;
         hs_pipe  <= '0;
         vs_pipe  <= '0;
         red       <= 8'h00;
         green     <= 8'h00;
         blue      <= 8'h00;
         rgb_valid <= 1'b0;
      end else begin
         if (pix_valid) pal_addr <= addr_nxt;
         gray_d1  <= grayscale;
         cidx     <= gray_d1 ? (pal_data[5:0] & 6'h30)
                             : pal_data[5:0];
         vld_pipe <= {vld_pipe[0], pix_valid};
         bl_pipe  <= {bl_pipe[LATENCY-2:0], blank_in};
         hs_pipe  <= {hs_pipe[LATENCY-2:0], hsync_in};
         vs_pipe  <= {vs_pipe[LATENCY-2:0], vsync_in};
         {red, green, blue} <= bl_pipe[1] ? BLANK_RGB
                                          : nes_rgb(cidx);
         rgb_valid <= vld_pipe[1] & !bl_pipe[1];
      end
   end

   // Set outranks clear so a hit on the clearing pixel is not lost.
   always_ff @(posedge clk) begin
      if (reset)            sprite0_hit <= 1'b0;
      else if (hit_set)     sprite0_hit <= 1'b1;
      else if (clr_sprite0) sprite0_hit <= 1'b0;
   end

   assign blank_out = bl_pipe[LATENCY-1];
   assign hsync_out = hs_pipe[LATENCY-1];
   assign vsync_out = vs_pipe[LATENCY-1];

endmodule

// File: tb/tb_palette_pixel_reader.sv
// Directed bench for palette_pixel_reader with a modelled async palette RAM.
module tb_palette_pixel_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       pix_valid;
   logic [3:0] bg_pix;
   logic [3:0] spr_pix;
   logic       spr_behind;
   logic       spr_zero;
   logic       show_bg;
   logic       show_spr;
   logic       grayscale;
   logic       blank_in;
   logic       hsync_in;
   logic       vsync_in;
   logic       clr_sprite0;
   logic [4:0] pal_addr;
   logic [7:0] pal_data;
   logic [7:0] red;
   logic [7:0] green;
   logic [7:0] blue;
   logic       rgb_valid;
   logic       blank_out;
   logic       hsync_out;
   logic       vsync_out;
   logic       sprite0_hit;

   logic [7:0] pal_mem [32];
   int         n_vec = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   assign pal_data = pal_mem[pal_addr];

   palette_pixel_reader dut (
      .clk(clk), .reset(reset),
      .pix_valid(pix_valid),
      .bg_pix(bg_pix), .spr_pix(spr_pix),
      .spr_behind(spr_behind), .spr_zero(spr_zero),
      .show_bg(show_bg), .show_spr(show_spr),
      .grayscale(grayscale),
      .blank_in(blank_in), .hsync_in(hsync_in),
      .vsync_in(vsync_in),
      .clr_sprite0(clr_sprite0),
      .pal_addr(pal_addr), .pal_data(pal_data),
      .red(red), .green(green), .blue(blue),
      .rgb_valid(rgb_valid),
      .blank_out(blank_out), .hsync_out(hsync_out),
      .vsync_out(vsync_out),
      .sprite0_hit(sprite0_hit)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [23:0] got,
                      input logic [23:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) pal_mem[i] = 8'h3F;
      pal_mem[5'h00] = 8'h22;
      pal_mem[5'h05] = 8'h22;
      pal_mem[5'h1C] = 8'h0F;
      pal_mem[5'h16] = 8'h30;
      pal_mem[5'h01] = 8'h0D;
      pal_mem[5'h09] = 8'h29;

      reset = 1; pix_valid = 0;
      bg_pix = 0; spr_pix = 0;
      spr_behind = 0; spr_zero = 0;
      show_bg = 0; show_spr = 0;
      grayscale = 0; blank_in = 1;
      hsync_in = 0; vsync_in = 0;
      clr_sprite0 = 0;
      tick(); tick();
      chk("rst_addr", 24'(pal_addr), 24'h00);
      chk("rst_rgb", {red, green, blue}, 24'h0);
      chk("rst_vld", 24'(rgb_valid), 24'h0);
      chk("rst_blank", 24'(blank_out), 24'h1);
      chk("rst_hs", 24'(hsync_out), 24'h0);
      chk("rst_vs", 24'(vsync_out), 24'h0);
      chk("rst_hit", 24'(sprite0_hit), 24'h0);

      reset = 0; blank_in = 0;
      pix_valid = 1; show_bg = 1;
      bg_pix = 4'h5;
      tick();
      chk("bg_addr", 24'(pal_addr), 24'h05);
      pix_valid = 0;
      tick();
      chk("addr_hold", 24'(pal_addr), 24'h05);
      tick();
      chk("bg_rgb", {red, green, blue}, 24'h5C94FC);
      chk("bg_vld", 24'(rgb_valid), 24'h1);
      tick();
      chk("bubble_vld", 24'(rgb_valid), 24'h0);

      pix_valid = 1; show_spr = 1;
      bg_pix = 4'h4; spr_pix = 4'hC;
      tick();
      chk("transp_addr", 24'(pal_addr), 24'h00);
      pix_valid = 0;
      tick(); tick();
      chk("transp_rgb", {red, green, blue}, 24'h5C94FC);
      chk("transp_vld", 24'(rgb_valid), 24'h1);

      pix_valid = 1;
      bg_pix = 4'h1; spr_pix = 4'h6;
      spr_behind = 0;
      tick();
      chk("pri_front", 24'(pal_addr), 24'h16);
      spr_behind = 1;
      tick();
      chk("pri_behind", 24'(pal_addr), 24'h01);
      show_bg = 0;
      tick();
      chk("pri_nobg", 24'(pal_addr), 24'h16);
      chk("pri_front_rgb", {red, green, blue}, 24'hFCFCFC);

      show_bg = 1; show_spr = 0;
      bg_pix = 4'h9; spr_pix = 4'h0;
      grayscale = 1;
      tick();
      chk("gray_addr", 24'(pal_addr), 24'h09);
      chk("pri_behind_rgb", {red, green, blue}, 24'h000000);
      blank_in = 1;
      tick();
      chk("pri_nobg_rgb", {red, green, blue}, 24'hFCFCFC);
      pix_valid = 0; blank_in = 0; grayscale = 0;
      tick();
      chk("gray_rgb", {red, green, blue}, 24'hFCFCFC);
      chk("gray_vld", 24'(rgb_valid), 24'h1);
      chk("gray_blank", 24'(blank_out), 24'h0);
      tick();
      chk("blank_rgb", {red, green, blue}, 24'h000000);
      chk("blank_vld", 24'(rgb_valid), 24'h0);
      chk("blank_out", 24'(blank_out), 24'h1);
      tick();
      chk("blank_end", 24'(blank_out), 24'h0);

      chk("hit_idle", 24'(sprite0_hit), 24'h0);
      pix_valid = 1; show_bg = 1; show_spr = 1;
      bg_pix = 4'h1; spr_pix = 4'h6;
      spr_behind = 1; spr_zero = 1;
      tick();
      chk("hit_set", 24'(sprite0_hit), 24'h1);
      spr_zero = 0;
      tick();
      chk("hit_sticky", 24'(sprite0_hit), 24'h1);
      clr_sprite0 = 1;
      tick();
      chk("hit_clr", 24'(sprite0_hit), 24'h0);
      spr_zero = 1;
      tick();
      chk("hit_set_wins", 24'(sprite0_hit), 24'h1);
      spr_zero = 0;
      tick();
      chk("hit_clr2", 24'(sprite0_hit), 24'h0);
      clr_sprite0 = 0; spr_zero = 1;
      blank_in = 1;
      tick();
      chk("hit_blank", 24'(sprite0_hit), 24'h0);
      blank_in = 0; bg_pix = 4'h4;
      tick();
      chk("hit_bg_tr", 24'(sprite0_hit), 24'h0);
      bg_pix = 4'h1; pix_valid = 0;
      tick();
      chk("hit_novld", 24'(sprite0_hit), 24'h0);
      pix_valid = 1;
      tick();
      chk("hit_again", 24'(sprite0_hit), 24'h1);
      spr_zero = 0;

      pix_valid = 0; hsync_in = 1;
      tick();
      hsync_in = 0; vsync_in = 1;
      chk("hs_d1", 24'(hsync_out), 24'h0);
      tick();
      vsync_in = 0;
      chk("hs_d2", 24'(hsync_out), 24'h0);
      tick();
      chk("hs_d3", 24'(hsync_out), 24'h1);
      chk("vs_d2", 24'(vsync_out), 24'h0);
      tick();
      chk("hs_d4", 24'(hsync_out), 24'h0);
      chk("vs_d3", 24'(vsync_out), 24'h1);

      show_spr = 0; bg_pix = 4'h5;
      for (int i = 0; i < 10; i++) begin
         pix_valid = 1;
         reset = (i == 5);
         tick();
         if (i == 4)
            chk("strm_vld", 24'(rgb_valid), 24'h1);
         if (i == 5) begin
            chk("srst_addr", 24'(pal_addr), 24'h00);
            chk("srst_rgb", {red, green, blue}, 24'h0);
            chk("srst_vld", 24'(rgb_valid), 24'h0);
            chk("srst_blank", 24'(blank_out), 24'h1);
            chk("srst_hit", 24'(sprite0_hit), 24'h0);
         end
         if (i == 6 || i == 7)
            chk("no_stale", 24'(rgb_valid), 24'h0);
         if (i == 8) begin
            chk("first_vld", 24'(rgb_valid), 24'h1);
            chk("first_rgb", {red, green, blue}, 24'h5C94FC);
         end
      end
      reset = 0;

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
